// File: rtl/execute_stage.sv
// execute_stage: EX pipeline stage. It forwards operands, runs the ALU, resolves
// beq branches and runs an iterative shift-add multiplier that stalls the front end.
// Results are registered into EX/MEM.
// Optional feature macro: EXEC_FORWARD_EN (EX/MEM and WB operand forwarding).
// The R-type function code port is named funct because "function" is a reserved word.

module execute_stage #(
    parameter int unsigned RADIX_BITS = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        en,
    input  logic [31:0] rega_data,
    input  logic [31:0] regb_data,
    input  logic [31:0] imm,
    input  logic [31:0] pc_next,
    input  logic [4:0]  rega,
    input  logic [4:0]  regb,
    input  logic [4:0]  rd_reg,
    input  logic [4:0]  rd_imme,
    input  logic        alu_reg_dest,
    input  logic        is_branch,
    input  logic        is_immediate,
    input  logic        wb_en,
    input  logic        mem_r_en,
    input  logic        mem_w_en,
    input  logic        mem_to_reg,
    input  logic [1:0]  alu_op,
    input  logic [5:0]  funct,
    input  logic        wb_fwd_en,
    input  logic [4:0]  wb_fwd_reg,
    input  logic [31:0] wb_fwd_data,
    output logic        stall_req,
    output logic [31:0] exm_alu_result,
    output logic [31:0] exm_store_data,
    output logic [4:0]  exm_dest,
    output logic        exm_wb_en,
    output logic        exm_mem_r_en,
    output logic        exm_mem_w_en,
    output logic        exm_mem_to_reg,
    output logic        branch_taken,
    output logic [31:0] branch_target
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned N      = DATA_W / RADIX_BITS;
    localparam int unsigned CNT_W  = 6;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_XOR = 6'b100110;
    localparam logic [5:0] F_SLT = 6'b101010;
    localparam logic [5:0] F_SLL = 6'b000000;
    localparam logic [5:0] F_SRL = 6'b000010;
    localparam logic [5:0] F_MUL = 6'b011000;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t              state, state_next;
    logic [CNT_W-1:0]    cnt, cnt_next;
    logic [DATA_W-1:0]   op_a, op_b, alu_b, alu_result;
    logic [DATA_W-1:0]   mul_a, mul_b, mul_acc, mul_partial;
    logic [DATA_W-1:0]   br_target;
    logic [4:0]          shamt, dest;
    logic                is_mul, br_taken;
    logic                mul_start, mul_step, exm_capture, exm_bubble;

`ifdef EXEC_FORWARD_EN
    logic exm_fwd_ok, wb_fwd_ok;

    // Operand forwarding: EX/MEM result beats WB data; loads in EX/MEM never forward
    always_comb begin
        exm_fwd_ok = exm_wb_en && !exm_mem_r_en && (exm_dest != 5'd0);
        wb_fwd_ok  = wb_fwd_en && (wb_fwd_reg != 5'd0);
        if (exm_fwd_ok && (exm_dest == rega))       op_a = exm_alu_result;
        else if (wb_fwd_ok && (wb_fwd_reg == rega)) op_a = wb_fwd_data;
        else                                        op_a = rega_data;
        if (exm_fwd_ok && (exm_dest == regb))       op_b = exm_alu_result;
        else if (wb_fwd_ok && (wb_fwd_reg == regb)) op_b = wb_fwd_data;
        else                                        op_b = regb_data;
    end
`else
    logic unused_fwd;

    // Operands straight from the register file; forwarding inputs are unused
    always_comb begin
        op_a       = rega_data;
        op_b       = regb_data;
        unused_fwd = &{1'b0, rega, regb, wb_fwd_en, wb_fwd_reg, wb_fwd_data};
    end
`endif

    // Operand select, destination select and branch resolution
    always_comb begin
        alu_b     = is_immediate ? imm : op_b;
        shamt     = imm[10:6];
        dest      = alu_reg_dest ? rd_imme : rd_reg;
        is_mul    = (alu_op == 2'b10) && (funct == F_MUL);
        br_taken  = is_branch && (alu_op == 2'b01) && (op_a == op_b);
        br_target = pc_next + {imm[29:0], 2'b00};
    end

    // ALU; the mul code returns the finished multiplier accumulator
    always_comb begin
        alu_result = '0;
        case (alu_op)
            2'b00: alu_result = op_a + alu_b;
            2'b01: alu_result = op_a - alu_b;
            2'b11: alu_result = op_a | alu_b;
            default: begin
                case (funct)
                    F_ADD:   alu_result = op_a + alu_b;
                    F_SUB:   alu_result = op_a - alu_b;
                    F_AND:   alu_result = op_a & alu_b;
                    F_OR:    alu_result = op_a | alu_b;
                    F_XOR:   alu_result = op_a ^ alu_b;
                    F_SLT:   alu_result = DATA_W'($signed(op_a) < $signed(alu_b));
                    F_SLL:   alu_result = alu_b << shamt;
                    F_SRL:   alu_result = alu_b >> shamt;
                    F_MUL:   alu_result = mul_acc;
                    default: alu_result = '0;
                endcase
            end
        endcase
    end

    // Partial product for the multiplier bits retired this cycle
    always_comb begin
        mul_partial = mul_a * DATA_W'(mul_b[RADIX_BITS-1:0]);
    end

    // Multiplier FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Multiplier FSM next state, stall request and EX/MEM load control
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        stall_req   = 1'b0;
        mul_start   = 1'b0;
        mul_step    = 1'b0;
        exm_capture = 1'b0;
        exm_bubble  = 1'b0;
        case (state)
            S_IDLE: begin
                if (en) begin
                    if (is_mul) begin
                        stall_req  = 1'b1;
                        mul_start  = 1'b1;
                        exm_bubble = 1'b1;
                        cnt_next   = '0;
                        state_next = S_BUSY;
                    end else begin
                        exm_capture = 1'b1;
                    end
                end
            end
            S_BUSY: begin
                stall_req = 1'b1;
                if (en) begin
                    mul_step   = 1'b1;
                    exm_bubble = 1'b1;
                    if (cnt == CNT_W'(N - 1)) begin
                        cnt_next   = '0;
                        state_next = S_DONE;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
            end
            S_DONE: begin
                if (en) begin
                    exm_capture = 1'b1;
                    state_next  = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
        if (flush) begin
            state_next  = S_IDLE;
            cnt_next    = '0;
            mul_start   = 1'b0;
            mul_step    = 1'b0;
            exm_capture = 1'b0;
            exm_bubble  = 1'b1;
        end
    end

    // Multiplier datapath: latch operands, then shift-add RADIX_BITS per step
    always_ff @(posedge clk) begin
        if (reset) begin
            mul_a   <= '0;
            mul_b   <= '0;
            mul_acc <= '0;
        end else if (mul_start) begin
            mul_a   <= op_a;
            mul_b   <= op_b;
            mul_acc <= '0;
        end else if (mul_step) begin
            mul_acc <= mul_acc + mul_partial;
            mul_a   <= mul_a << RADIX_BITS;
            mul_b   <= mul_b >> RADIX_BITS;
        end
    end

    // EX/MEM pipeline register
    always_ff @(posedge clk) begin
        if (reset || exm_bubble) begin
            exm_alu_result <= '0;
            exm_store_data <= '0;
            exm_dest       <= '0;
            exm_wb_en      <= 1'b0;
            exm_mem_r_en   <= 1'b0;
            exm_mem_w_en   <= 1'b0;
            exm_mem_to_reg <= 1'b0;
            branch_taken   <= 1'b0;
            branch_target  <= '0;
        end else if (exm_capture) begin
            exm_alu_result <= alu_result;
            exm_store_data <= op_b;
            exm_dest       <= dest;
            exm_wb_en      <= wb_en && !is_branch;
            exm_mem_r_en   <= mem_r_en;
            exm_mem_w_en   <= mem_w_en;
            exm_mem_to_reg <= mem_to_reg;
            branch_taken   <= br_taken;
            branch_target  <= br_target;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: vector table, directed multi-cycle sequences and a randomized
// run against a behavioural model of the execute stage.

module tb_execute_stage;

    localparam int unsigned RADIX = 1;
    localparam int unsigned NCYC  = 32 / RADIX;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_XOR = 6'b100110;
    localparam logic [5:0] F_SLT = 6'b101010;
    localparam logic [5:0] F_SLL = 6'b000000;
    localparam logic [5:0] F_SRL = 6'b000010;
    localparam logic [5:0] F_MUL = 6'b011000;

    logic        clk = 1'b0;
    logic        reset, flush, en;
    logic [31:0] rega_data, regb_data, imm, pc_next, wb_fwd_data;
    logic [4:0]  rega, regb, rd_reg, rd_imme, wb_fwd_reg;
    logic        alu_reg_dest, is_branch, is_immediate, wb_en, mem_r_en, mem_w_en, mem_to_reg;
    logic [1:0]  alu_op;
    logic [5:0]  funct;
    logic        wb_fwd_en;
    logic        stall_req;
    logic [31:0] exm_alu_result, exm_store_data, branch_target;
    logic [4:0]  exm_dest;
    logic        exm_wb_en, exm_mem_r_en, exm_mem_w_en, exm_mem_to_reg, branch_taken;

    int n_checks = 0;
    int n_fail   = 0;

    execute_stage #(.RADIX_BITS(RADIX)) dut (
        .clk(clk), .reset(reset), .flush(flush), .en(en),
        .rega_data(rega_data), .regb_data(regb_data), .imm(imm), .pc_next(pc_next),
        .rega(rega), .regb(regb), .rd_reg(rd_reg), .rd_imme(rd_imme),
        .alu_reg_dest(alu_reg_dest), .is_branch(is_branch), .is_immediate(is_immediate),
        .wb_en(wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .mem_to_reg(mem_to_reg),
        .alu_op(alu_op), .funct(funct),
        .wb_fwd_en(wb_fwd_en), .wb_fwd_reg(wb_fwd_reg), .wb_fwd_data(wb_fwd_data),
        .stall_req(stall_req),
        .exm_alu_result(exm_alu_result), .exm_store_data(exm_store_data), .exm_dest(exm_dest),
        .exm_wb_en(exm_wb_en), .exm_mem_r_en(exm_mem_r_en), .exm_mem_w_en(exm_mem_w_en),
        .exm_mem_to_reg(exm_mem_to_reg), .branch_taken(branch_taken), .branch_target(branch_target)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a, b, imm, pc;
        logic [4:0]  ra, rb, rd_reg, rd_imme;
        logic        reg_dest, is_branch, is_imm, wb_en, mem_r, mem_w, m2r;
        logic [1:0]  op;
        logic [5:0]  f;
        logic        wf_en;
        logic [4:0]  wf_reg;
        logic [31:0] wf_data;
    } in_t;

    typedef struct {
        logic [31:0] alu, store;
        logic [4:0]  dest;
        logic        wb, mr, mw, m2r, bt;
        logic [31:0] tgt;
    } exm_t;

    typedef struct {
        in_t  i;
        exm_t e;
    } vec_t;

    function automatic in_t nop_in();
        in_t x;
        x.a = '0; x.b = '0; x.imm = '0; x.pc = '0;
        x.ra = '0; x.rb = '0; x.rd_reg = '0; x.rd_imme = '0;
        x.reg_dest = 1'b0; x.is_branch = 1'b0; x.is_imm = 1'b0; x.wb_en = 1'b0;
        x.mem_r = 1'b0; x.mem_w = 1'b0; x.m2r = 1'b0; x.op = '0; x.f = '0;
        x.wf_en = 1'b0; x.wf_reg = '0; x.wf_data = '0;
        return x;
    endfunction

    function automatic in_t alu_in(logic [1:0] op, logic [5:0] f, logic [31:0] a, logic [31:0] b,
                                   logic [31:0] im, logic is_imm);
        in_t x = nop_in();
        x.op = op; x.f = f; x.a = a; x.b = b; x.imm = im; x.is_imm = is_imm;
        x.wb_en = 1'b1; x.reg_dest = 1'b1; x.rd_imme = 5'd3; x.rd_reg = 5'd1;
        return x;
    endfunction

    function automatic exm_t ex(logic [31:0] alu, logic [31:0] store, logic [4:0] dest,
                                logic wb, logic mr, logic bt, logic [31:0] tgt);
        exm_t e;
        e.alu = alu; e.store = store; e.dest = dest; e.wb = wb; e.mr = mr; e.mw = 1'b0;
        e.m2r = mr; e.bt = bt; e.tgt = tgt;
        return e;
    endfunction

    function automatic exm_t exm_zero();
        return ex(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0);
    endfunction

    // Value an instruction sees for a source register, given the previous EX/MEM contents
    function automatic logic [31:0] src_val(logic [4:0] r, logic [31:0] d, in_t x, exm_t prev);
`ifdef EXEC_FORWARD_EN
        if (prev.wb && !prev.mr && prev.dest != 0 && prev.dest == r) return prev.alu;
        if (x.wf_en && x.wf_reg != 0 && x.wf_reg == r) return x.wf_data;
`endif
        return d;
    endfunction

    // Behavioural reference: what EX/MEM should hold after capturing instruction x
    function automatic exm_t model_step(in_t x, exm_t prev);
        exm_t e;
        logic [31:0] fa, fb, ob;
        fa = src_val(x.ra, x.a, x, prev);
        fb = src_val(x.rb, x.b, x, prev);
        ob = x.is_imm ? x.imm : fb;
        case (x.op)
            2'd0: e.alu = fa + ob;
            2'd1: e.alu = fa - ob;
            2'd3: e.alu = fa | ob;
            default: begin
                if      (x.f == F_ADD) e.alu = fa + ob;
                else if (x.f == F_SUB) e.alu = fa - ob;
                else if (x.f == F_AND) e.alu = fa & ob;
                else if (x.f == F_OR)  e.alu = fa | ob;
                else if (x.f == F_XOR) e.alu = fa ^ ob;
                else if (x.f == F_SLT) e.alu = ($signed(fa) < $signed(ob)) ? 32'd1 : 32'd0;
                else if (x.f == F_SLL) e.alu = ob << x.imm[10:6];
                else if (x.f == F_SRL) e.alu = ob >> x.imm[10:6];
                else if (x.f == F_MUL) e.alu = fa * fb;
                else                   e.alu = 32'd0;
            end
        endcase
        e.store = fb;
        e.dest  = x.reg_dest ? x.rd_imme : x.rd_reg;
        e.wb    = x.wb_en && !x.is_branch;
        e.mr    = x.mem_r;
        e.mw    = x.mem_w;
        e.m2r   = x.m2r;
        e.bt    = x.is_branch && x.op == 2'd1 && fa == fb;
        e.tgt   = x.pc + x.imm * 32'd4;
        return e;
    endfunction

    task automatic drive(input in_t x);
        rega_data = x.a; regb_data = x.b; imm = x.imm; pc_next = x.pc;
        rega = x.ra; regb = x.rb; rd_reg = x.rd_reg; rd_imme = x.rd_imme;
        alu_reg_dest = x.reg_dest; is_branch = x.is_branch; is_immediate = x.is_imm;
        wb_en = x.wb_en; mem_r_en = x.mem_r; mem_w_en = x.mem_w; mem_to_reg = x.m2r;
        alu_op = x.op; funct = x.f;
        wb_fwd_en = x.wf_en; wb_fwd_reg = x.wf_reg; wb_fwd_data = x.wf_data;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_exm(input string nm, input exm_t e);
        logic ok;
        n_checks++;
        ok = (exm_alu_result === e.alu) && (exm_store_data === e.store) && (exm_dest === e.dest) &&
             (exm_wb_en === e.wb) && (exm_mem_r_en === e.mr) && (exm_mem_w_en === e.mw) &&
             (exm_mem_to_reg === e.m2r) && (branch_taken === e.bt) &&
             (!e.bt || branch_target === e.tgt);
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got alu=%h st=%h d=%0d wb=%b mr=%b mw=%b m2r=%b bt=%b tgt=%h expected alu=%h st=%h d=%0d wb=%b mr=%b mw=%b m2r=%b bt=%b tgt=%h",
                     nm, exm_alu_result, exm_store_data, exm_dest, exm_wb_en, exm_mem_r_en,
                     exm_mem_w_en, exm_mem_to_reg, branch_taken, branch_target,
                     e.alu, e.store, e.dest, e.wb, e.mr, e.mw, e.m2r, e.bt, e.tgt);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Multiply sequence with an optional en=0 freeze window (cycle index in EX)
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input int freeze_at,
                           input int freeze_len, input string nm);
        in_t x;
        int  stalls = 0;
        int  bubble_bad = 0;
        bit  done = 1'b0;
        logic [31:0] prod = a * b;
        drive(alu_in(2'b00, 6'd0, 32'h11, 32'h0, 32'h22, 1'b1));
        tick();
        x = alu_in(2'b10, F_MUL, a, b, 32'h0, 1'b0);
        x.rd_imme = 5'd9;
        drive(x);
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            en = (cyc >= freeze_at && cyc < freeze_at + freeze_len) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (stall_req) stalls++;
            else done = 1'b1;
            tick();
            if (!done && (exm_wb_en || exm_alu_result != 0)) bubble_bad++;
        end
        en = 1'b1;
        check32({nm, "_finished"}, 32'(done), 32'd1);
        check32({nm, "_stall_cycles"}, 32'(stalls), 32'(NCYC + 1 + freeze_len));
        check32({nm, "_bubbles"}, 32'(bubble_bad), 32'd0);
        check32({nm, "_product"}, exm_alu_result, prod);
        check32({nm, "_dest_wb"}, {26'd0, exm_wb_en, exm_dest}, {26'd0, 1'b1, 5'd9});
        drive(nop_in());
        @(negedge clk);
        check32({nm, "_stall_drop"}, 32'(stall_req), 32'd0);
        tick();
    endtask

    vec_t tbl[17];
    exm_t m;
    in_t  x;

    initial begin
        reset = 1'b1; flush = 1'b0; en = 1'b1;
        drive(nop_in());
        tick();
        tick();
        check_exm("reset_state", exm_zero());
        check32("reset_stall", 32'(stall_req), 32'd0);
        reset = 1'b0;

        // Single-cycle vectors; sources are r0 so nothing forwards
        tbl[0].i  = alu_in(2'b10, F_ADD, 32'd5, 32'd7, 32'h0, 1'b0);
        tbl[0].e  = ex(32'd12, 32'd7, 5'd3, 1'b1, 1'b0, 1'b0, 32'h0);
        tbl[1].i  = alu_in(2'b10, F_SUB, 32'd5, 32'd7, 32'h0, 1'b0);
        tbl[1].e  = ex(32'hFFFFFFFE, 32'd7, 5'd3, 1'b1, 1'b0, 1'b0, 32'h0);
        tbl[2].i  = alu_in(2'b10, F_AND, 32'hF0F0, 32'hFF00, 32'h0, 1'b0);
        tbl[2].e  = ex(32'hF000, 32'hFF00, 5'd3, 1'b1, 1'b0, 1'b0, 32'h0);
        tbl[3].i  = alu_in(2'b10, F_OR, 32'hF0F0, 32'h0F0F, 32'h0, 1'b0);
        tbl[3].e  = ex(32'hFFFF, 32'h0F0F, 5'd3, 1'b1, 1'b0, 1'b0, 32'h0);
        tbl[4].i  = alu_in(2'b10, F_XOR, 32'hFF00, 32'h0FF0, 32'h0, 1'b0);
        tbl[4].e  = ex(32'hF0F0, 32'h0FF0, 5'd3, 1'b1, 1'b0, 1'b0, 32'h0);
        tbl[5].i  = alu_in(2'b10, F_SLT, 32'hFFFFFFFF, 32'd1, 32'h0, 1'b0);
        tbl[5].e  = ex(32'd1, 32'd1, 5'd3, 1'b1, 1'b0, 1'b0, 32'h0);
        tbl[6].i  = alu_in(2'b10, F_SLT, 32'd1, 32'hFFFFFFFF, 32'h0, 1'b0);
        tbl[6].e  = ex(32'd0, 32'hFFFFFFFF, 5'd3, 1'b1, 1'b0, 1'b0, 32'h0);
        tbl[7].i  = alu_in(2'b10, F_SLL, 32'd0, 32'd1, 32'h7C0, 1'b0);
        tbl[7].e  = ex(32'h80000000, 32'd1, 5'd3, 1'b1, 1'b0, 1'b0, 32'h0);
        tbl[8].i  = alu_in(2'b10, F_SRL, 32'd0, 32'h80000000, 32'h100, 1'b0);
        tbl[8].e  = ex(32'h08000000, 32'h80000000, 5'd3, 1'b1, 1'b0, 1'b0, 32'h0);
        tbl[9].i  = alu_in(2'b10, 6'b111111, 32'd5, 32'd7, 32'h0, 1'b0);
        tbl[9].e  = ex(32'd0, 32'd7, 5'd3, 1'b1, 1'b0, 1'b0, 32'h0);
        tbl[10].i = alu_in(2'b11, 6'd0, 32'h30, 32'h1234, 32'hF, 1'b1);
        tbl[10].e = ex(32'h3F, 32'h1234, 5'd3, 1'b1, 1'b0, 1'b0, 32'h0);
        tbl[11].i = alu_in(2'b00, 6'd0, 32'hFFFFFFFF, 32'h77, 32'd2, 1'b1);
        tbl[11].e = ex(32'd1, 32'h77, 5'd3, 1'b1, 1'b0, 1'b0, 32'h0);
        tbl[12].i = alu_in(2'b00, 6'd0, 32'h1000, 32'h0, 32'hFFFFFFFC, 1'b1);
        tbl[12].i.mem_r = 1'b1; tbl[12].i.m2r = 1'b1; tbl[12].i.reg_dest = 1'b0;
        tbl[12].e = ex(32'hFFC, 32'h0, 5'd1, 1'b1, 1'b1, 1'b0, 32'h0);
        tbl[13].i = alu_in(2'b01, 6'd0, 32'd4, 32'd4, 32'hFFFFFFFE, 1'b0);
        tbl[13].i.is_branch = 1'b1; tbl[13].i.pc = 32'h100;
        tbl[13].e = ex(32'd0, 32'd4, 5'd3, 1'b0, 1'b0, 1'b1, 32'hF8);
        tbl[14].i = alu_in(2'b01, 6'd0, 32'd4, 32'd5, 32'hFFFFFFFE, 1'b0);
        tbl[14].i.is_branch = 1'b1; tbl[14].i.pc = 32'h100;
        tbl[14].e = ex(32'hFFFFFFFF, 32'd5, 5'd3, 1'b0, 1'b0, 1'b0, 32'h0);
        tbl[15].i = alu_in(2'b01, 6'd0, 32'd10, 32'd3, 32'h0, 1'b0);
        tbl[15].e = ex(32'd7, 32'd3, 5'd3, 1'b1, 1'b0, 1'b0, 32'h0);
        tbl[16].i = alu_in(2'b00, 6'd0, 32'h200, 32'hCAFE, 32'd8, 1'b1);
        tbl[16].i.mem_w = 1'b1; tbl[16].i.wb_en = 1'b0;
        tbl[16].e = ex(32'h208, 32'hCAFE, 5'd3, 1'b0, 1'b0, 1'b0, 32'h0);
        tbl[16].e.mw = 1'b1;

        // Vectors 13..15 also show branch_taken as a single-cycle pulse
        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].i);
            tick();
            check_exm($sformatf("vec%0d", i), tbl[i].e);
        end

        // en=0 holds EX/MEM
        en = 1'b0;
        drive(tbl[0].i);
        tick();
        check_exm("en_low_hold", tbl[16].e);
        en = 1'b1;

        // WB writing r0 never forwards
        x = alu_in(2'b11, 6'd0, 32'h0, 32'h0, 32'hF, 1'b1);
        x.wf_en = 1'b1; x.wf_reg = 5'd0; x.wf_data = 32'd99;
        drive(x);
        tick();
        check32("wb_r0_not_fwd", exm_alu_result, 32'hF);

        // Dependent chain: EX/MEM forward, WB forward, priority, load not forwarded
        do_reset();
        m = exm_zero();
        x = alu_in(2'b00, 6'd0, 32'h0, 32'h0, 32'd5, 1'b1);
        x.reg_dest = 1'b0; x.rd_reg = 5'd1;
        drive(x); tick(); m = model_step(x, m); check_exm("chain_r1", m);
        x = alu_in(2'b10, F_ADD, 32'hDEAD0000, 32'd7, 32'h0, 1'b0);
        x.ra = 5'd1; x.rb = 5'd2; x.rd_imme = 5'd3;
        drive(x); tick(); m = model_step(x, m); check_exm("chain_r3", m);
`ifdef EXEC_FORWARD_EN
        check32("fwd_exm_add", exm_alu_result, 32'd12);
`endif
        x = alu_in(2'b10, F_ADD, 32'h0, 32'd1, 32'h0, 1'b0);
        x.ra = 5'd3; x.rb = 5'd5; x.rd_imme = 5'd4;
        x.wf_en = 1'b1; x.wf_reg = 5'd5; x.wf_data = 32'd100;
        drive(x); tick(); m = model_step(x, m); check_exm("chain_wb_fwd", m);
        x = alu_in(2'b10, F_OR, 32'h0, 32'h0, 32'h0, 1'b0);
        x.ra = 5'd4; x.rd_imme = 5'd6;
        x.wf_en = 1'b1; x.wf_reg = 5'd4; x.wf_data = 32'd7;
        drive(x); tick(); m = model_step(x, m); check_exm("chain_priority", m);
        x = alu_in(2'b00, 6'd0, 32'h1000, 32'h0, 32'hFFFFFFFC, 1'b1);
        x.mem_r = 1'b1; x.m2r = 1'b1; x.reg_dest = 1'b0; x.rd_reg = 5'd6;
        drive(x); tick(); m = model_step(x, m); check_exm("chain_lw", m);
        x = alu_in(2'b10, F_ADD, 32'h55, 32'h0, 32'h0, 1'b0);
        x.ra = 5'd6; x.rd_imme = 5'd7;
        drive(x); tick(); m = model_step(x, m); check_exm("chain_load_use", m);
        check32("load_not_fwd", exm_alu_result, 32'h55);

        // Multiplies
        run_mul(32'd7, 32'hFFFFFFFD, 1000, 0, "mul_neg");
        run_mul($urandom, $urandom, 1000, 0, "mul_rand");
        run_mul($urandom, $urandom, 5, 4, "mul_freeze");

        // Flush during the 10th BUSY cycle
        begin
            int late_stall = 0;
            int late_wb = 0;
            x = alu_in(2'b10, F_MUL, 32'd6, 32'd9, 32'h0, 1'b0);
            x.rd_imme = 5'd9;
            drive(x);
            for (int i = 0; i < 10; i++) tick();
            flush = 1'b1;
            tick();
            flush = 1'b0;
            check_exm("flush_bubble", exm_zero());
            drive(nop_in());
            @(negedge clk);
            check32("flush_stall_drop", 32'(stall_req), 32'd0);
            for (int i = 0; i < 40; i++) begin
                tick();
                if (stall_req) late_stall++;
                if (exm_wb_en || exm_alu_result != 0) late_wb++;
            end
            check32("flush_no_stall", 32'(late_stall), 32'd0);
            check32("flush_no_result", 32'(late_wb), 32'd0);
        end

        // Randomized single-cycle traffic against the model
        do_reset();
        m = exm_zero();
        for (int n = 0; n < 400; n++) begin
            logic rst_now, fl_now, en_now;
            x = nop_in();
            x.op = 2'($urandom_range(0, 3));
            x.f  = 6'($urandom_range(0, 63));
            case ($urandom_range(0, 8))
                0: x.f = F_ADD; 1: x.f = F_SUB; 2: x.f = F_AND; 3: x.f = F_OR;
                4: x.f = F_XOR; 5: x.f = F_SLT; 6: x.f = F_SLL; 7: x.f = F_SRL;
                default: ;
            endcase
            if (x.f == F_MUL) x.f = 6'b111111;
            x.a = $urandom;
            x.b = ($urandom_range(0, 3) == 0) ? x.a : $urandom;
            x.imm = $urandom;
            x.pc = $urandom;
            x.ra = 5'($urandom_range(0, 3));
            x.rb = 5'($urandom_range(0, 3));
            x.rd_reg = 5'($urandom_range(0, 3));
            x.rd_imme = 5'($urandom_range(0, 3));
            x.reg_dest = 1'($urandom_range(0, 1));
            x.is_branch = ($urandom_range(0, 3) == 0);
            if (x.is_branch && $urandom_range(0, 3) != 0) x.op = 2'd1;
            x.is_imm = 1'($urandom_range(0, 1));
            x.wb_en = 1'($urandom_range(0, 1));
            x.mem_r = ($urandom_range(0, 3) == 0);
            x.mem_w = ($urandom_range(0, 3) == 0);
            x.m2r = 1'($urandom_range(0, 1));
            x.wf_en = 1'($urandom_range(0, 1));
            x.wf_reg = 5'($urandom_range(0, 3));
            x.wf_data = $urandom;
            rst_now = ($urandom_range(0, 49) == 0);
            fl_now  = ($urandom_range(0, 19) == 0);
            en_now  = ($urandom_range(0, 9) != 0);
            drive(x);
            reset = rst_now; flush = fl_now; en = en_now;
            if (rst_now || fl_now) m = exm_zero();
            else if (en_now) m = model_step(x, m);
            tick();
            check_exm($sformatf("rand%0d", n), m);
        end
        reset = 1'b0; flush = 1'b0; en = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Consumer end of the ID/EX pipeline interface; sits between decode and memory stages.
- Takes decoded operands and control, forwards hazarding operands from EX/MEM and WB, runs the ALU, resolves beq branches, and runs an iterative multi-cycle multiplier that stalls the front end.
- Registers results into the EX/MEM pipeline register.

Parameters:
- RADIX_BITS, 1, multiplier bits retired per cycle (legal 1, 2, 4); N = 32/RADIX_BITS busy cycles.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- flush  in  1  clear EX/MEM to bubble, abort multiply
- en  in  1  pipeline advance enable; 0 holds EX/MEM register and multiplier state
- rega_data, regb_data  in  32  ID/EX register operands
- imm  in  32  sign-extended immediate; shamt = imm[10:6]
- pc_next  in  32  PC+4 of instruction
- rega, regb  in  5  source register numbers
- rd_reg  in  5  dest field [20:16]
- rd_imme  in  5  dest field [15:11]
- alu_reg_dest  in  1  1 selects rd_imme, 0 selects rd_reg
- is_branch, is_immediate, wb_en, mem_r_en, mem_w_en, mem_to_reg  in  1  control from ID/EX
- alu_op  in  2  00 add, 01 sub/compare, 10 use function, 11 or
- function  in  6  R-type function code
- wb_fwd_en  in  1  WB stage writes register
- wb_fwd_reg  in  5  WB destination
- wb_fwd_data  in  32  WB data
- stall_req  out  1  hold fetch/decode (combinational)
- exm_alu_result  out  32  registered result / memory address
- exm_store_data  out  32  registered forwarded B operand
- exm_dest  out  5  registered destination
- exm_wb_en, exm_mem_r_en, exm_mem_w_en, exm_mem_to_reg  out  1  registered control
- branch_taken  out  1  registered, one-cycle pulse
- branch_target  out  32  registered, valid with branch_taken

Behaviour:
- Reset: all outputs 0, FSM IDLE, counter 0. Priority: reset > flush > en.
- Forwarding (macro-gated): operand X = exm_alu_result when exm_wb_en && !exm_mem_r_en && exm_dest != 0 && exm_dest == regX. Otherwise wb_fwd_data when wb_fwd_en && wb_fwd_reg != 0 && match. Otherwise the register operand. EX/MEM has priority.
- Operand B to ALU = imm if is_immediate, else forwarded B. exm_store_data always takes forwarded B.
- Function codes: 100000 add, 100010 sub, 100100 and, 100101 or, 100110 xor, 101010 slt (signed, 0/1), 000000 sll by shamt, 000010 srl by shamt, 011000 mul (low 32 bits). Unknown codes produce 0.
- Arithmetic is modulo 2^32 with no overflow trap.
- Branch: is_branch && alu_op==01 && A==B gives branch_taken=1, branch_target = pc_next + (imm<<2). Wrap-around is allowed. Branch instructions are captured with exm_wb_en=0.
- Destination: alu_reg_dest ? rd_imme : rd_reg.
- EX/MEM register: when en=1 and not stalling, captures the computed values. When en=0, holds. Flush writes a bubble: all control 0 and data 0.
- Multiplier FSM:
  - IDLE: mul present (alu_op==10, function==011000) && en. stall_req=1 combinationally, latch forwarded A/B, EX/MEM gets bubble, go to BUSY with counter 0.
  - BUSY: stall_req=1, retire RADIX_BITS per cycle (shift-add, signed by two's-complement modulo), EX/MEM bubble. After N cycles go to DONE.
  - DONE: stall_req=0, EX/MEM captures product and mul controls, go to IDLE.
  - Total N+2 cycles in EX; stall_req high N+1 cycles.
  - en=0 in BUSY/DONE freezes the FSM and counter.
  - flush or reset in any state: go to IDLE, stall_req drops next cycle, no result written.
- Load-use hazards are detected outside this block.

Optional Feature:
- EXEC_FORWARD_EN defined: forwarding muxes as above.
- Not defined: operands taken directly from rega_data/regb_data; wb_fwd_* inputs are ignored (left unused).

Test Plan:
- add r3=r1+r2, previous instruction wrote r1=5 (in EX/MEM), r2=7 from regfile → exm_alu_result=12, exm_dest=3.
- wb_fwd writes r0=99 while rega=0, rega_data=0 → operand 0, not forwarded; or-immediate with imm=0xF → result 0xF.
- beq with A=B=4, pc_next=0x100, imm=0xFFFFFFFE → branch_taken pulse 1 cycle, branch_target=0xF8, exm_wb_en=0.
- mul 7 × 0xFFFFFFFD with RADIX_BITS=1 → stall_req high 33 cycles, result 0xFFFFFFEB on the 34th cycle's edge, bubbles before it.
- flush during BUSY cycle 10 → FSM IDLE, stall_req 0 next cycle, EX/MEM bubble, no mul result written.
- lw base 0x1000, imm 0xFFFFFFFC, mem_r_en=1 → exm_alu_result=0xFFC, exm_mem_r_en=1; a following dependent instruction is not forwarded from EX/MEM.
